// File: rtl/uarc_pkg.sv
// Shared types for the send scheduler: command opcodes and controller states.
// No logic here.
package uarc_pkg;

  typedef enum logic [1:0] {
    OP_KILL   = 2'd0,
    OP_INCEPT = 2'd1,
    OP_SEND   = 2'd2,
    OP_STREAM = 2'd3
  } uarc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RESP  = 2'd3
  } uarc_state_e;

endpackage

// File: rtl/uarc_ack_select.sv
// Picks the ack bit of the latched operation on the latched bus; zero latency, no backpressure.
// Bus indices beyond the bus count read as "no ack".
module uarc_ack_select import uarc_pkg::*; #(
  parameter int TOTAL_BUSES = 32,
  parameter int BUS_W       = 5
) (
  input  uarc_op_e               op,
  input  logic [BUS_W-1:0]       bus,
  input  logic [TOTAL_BUSES-1:0] kill_acks,
  input  logic [TOTAL_BUSES-1:0] incept_acks,
  input  logic [TOTAL_BUSES-1:0] send_acks,
  input  logic [TOTAL_BUSES-1:0] stream_acks,
  output logic                   ack
);

  localparam logic [BUS_W:0] BUS_LIMIT = (BUS_W + 1)'(TOTAL_BUSES);

  logic [TOTAL_BUSES-1:0] op_acks;

  always_comb begin
    op_acks = kill_acks;
    case (op)
      OP_KILL:   op_acks = kill_acks;
      OP_INCEPT: op_acks = incept_acks;
      OP_SEND:   op_acks = send_acks;
      OP_STREAM: op_acks = stream_acks;
      default:   op_acks = kill_acks;
    endcase
    ack = 1'b0;
    if ({1'b0, bus} < BUS_LIMIT) ack = op_acks[bus];
  end

endmodule

// File: rtl/uarc_send_sched.sv
// Send scheduler: one command at a time onto a selected bus; drive from accept+1, rsp_valid at ack+1.
// cmd_ready low while driving/responding; a held stream only accepts STREAM. UARC_SEND_TIMEOUT_EN adds an ack timeout.
module uarc_send_sched import uarc_pkg::*; #(
  parameter  int WORD_MAG    = 5,
  parameter  int UARC_SETS   = 1,
  parameter  int TIMEOUT     = 1023,
  localparam int WORD_WIDTH  = 1 << WORD_MAG,
  localparam int TOTAL_BUSES = UARC_SETS * WORD_WIDTH,
  localparam int BUS_W       = $clog2(TOTAL_BUSES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [BUS_W-1:0]       cmd_bus,
  input  logic                   cmd_last,
  input  logic [WORD_WIDTH-1:0]  cmd_data,
  input  logic [WORD_WIDTH-1:0]  cmd_self_permission,
  input  logic [WORD_WIDTH-1:0]  cmd_self_address,
  input  logic [WORD_WIDTH-1:0]  cmd_incept_permission,
  input  logic [WORD_WIDTH-1:0]  cmd_incept_address,
  output logic                   global_kill,
  output logic                   global_incept,
  output logic                   global_send,
  output logic                   global_stream,
  output logic [WORD_WIDTH-1:0]  global_data,
  output logic [WORD_WIDTH-1:0]  global_self_permission,
  output logic [WORD_WIDTH-1:0]  global_self_address,
  output logic [WORD_WIDTH-1:0]  global_incept_permission,
  output logic [WORD_WIDTH-1:0]  global_incept_address,
  output logic [TOTAL_BUSES-1:0] sender_enables,
  input  logic [TOTAL_BUSES-1:0] sender_kill_acks,
  input  logic [TOTAL_BUSES-1:0] sender_incept_acks,
  input  logic [TOTAL_BUSES-1:0] sender_send_acks,
  input  logic [TOTAL_BUSES-1:0] sender_stream_acks,
  output logic                   rsp_valid,
  output logic                   rsp_error
);

  localparam logic [BUS_W:0] BUS_LIMIT = (BUS_W + 1)'(TOTAL_BUSES);

  uarc_state_e            state_q, state_d;
  uarc_op_e               op_q;
  logic [BUS_W-1:0]       bus_q;
  logic                   last_q;
  logic                   err_q;
  logic                   ack;
  logic                   rdy;
  logic                   accept;
  logic                   in_range;
  logic                   timeout_hit;
  logic [TOTAL_BUSES-1:0] bus_onehot;

  assign in_range   = ({1'b0, cmd_bus} < BUS_LIMIT);
  assign bus_onehot = TOTAL_BUSES'(1) << bus_q;
  // Ready is forced low while reset is held so nothing is offered as accepted.
  assign cmd_ready  = rdy & reset;
  assign accept     = cmd_valid & cmd_ready;

  uarc_ack_select #(
    .TOTAL_BUSES (TOTAL_BUSES),
    .BUS_W       (BUS_W)
  ) u_ack_select (
    .op          (op_q),
    .bus         (bus_q),
    .kill_acks   (sender_kill_acks),
    .incept_acks (sender_incept_acks),
    .send_acks   (sender_send_acks),
    .stream_acks (sender_stream_acks),
    .ack         (ack)
  );

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (accept) state_d = in_range ? ST_DRIVE : ST_RESP;
      end
      ST_DRIVE: begin
        if (ack) state_d = (op_q == OP_STREAM && !last_q) ? ST_HOLD : ST_RESP;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_HOLD: begin
        // The locked bus is reused; cmd_bus of continuation words is ignored.
        rdy = (uarc_op_e'(cmd_op) == OP_STREAM);
        if (accept) state_d = ST_DRIVE;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == ST_IDLE) err_q <= !in_range;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q                     <= OP_KILL;
      bus_q                    <= '0;
      last_q                   <= 1'b0;
      global_data              <= '0;
      global_self_permission   <= '0;
      global_self_address      <= '0;
      global_incept_permission <= '0;
      global_incept_address    <= '0;
    end else if (accept && (state_q == ST_HOLD || in_range)) begin
      op_q                     <= uarc_op_e'(cmd_op);
      last_q                   <= cmd_last;
      global_data              <= cmd_data;
      global_self_permission   <= cmd_self_permission;
      global_self_address      <= cmd_self_address;
      global_incept_permission <= cmd_incept_permission;
      global_incept_address    <= cmd_incept_address;
      if (state_q == ST_IDLE) bus_q <= cmd_bus;
    end
  end

`ifdef UARC_SEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Restarts on every state change, so each DRIVE or HOLD stay gets a fresh budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (state_q == ST_DRIVE || state_q == ST_HOLD) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = ((state_q == ST_DRIVE && !ack) || (state_q == ST_HOLD && !accept)) &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    sender_enables = '0;
    global_kill    = 1'b0;
    global_incept  = 1'b0;
    global_send    = 1'b0;
    global_stream  = 1'b0;
    rsp_valid      = 1'b0;
    rsp_error      = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        sender_enables = bus_onehot;
        case (op_q)
          OP_KILL:   global_kill   = 1'b1;
          OP_INCEPT: global_incept = 1'b1;
          OP_SEND:   global_send   = 1'b1;
          OP_STREAM: global_stream = 1'b1;
          default:   global_kill   = 1'b0;
        endcase
      end
      ST_HOLD: sender_enables = bus_onehot;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
      end
      default: sender_enables = '0;
    endcase
  end

endmodule

// File: tb/tb_uarc_send_sched.sv
// Bench for uarc_send_sched: directed scenarios with literal expectations plus random traffic
// against a transaction-level model checked every cycle.
module tb_uarc_send_sched;

  localparam int WORD_MAG  = 5;
  localparam int UARC_SETS = 3;
  localparam int TIMEOUT   = 8;
  localparam int WW        = 32;
  localparam int NB        = 96;
  localparam int BW        = 7;
`ifdef UARC_SEND_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [BW-1:0] cmd_bus = '0;
  logic cmd_last = 1'b0;
  logic [WW-1:0] cmd_data = '0, cmd_self_permission = '0, cmd_self_address = '0;
  logic [WW-1:0] cmd_incept_permission = '0, cmd_incept_address = '0;
  logic global_kill, global_incept, global_send, global_stream;
  logic [WW-1:0] global_data, global_self_permission, global_self_address;
  logic [WW-1:0] global_incept_permission, global_incept_address;
  logic [NB-1:0] sender_enables;
  logic [NB-1:0] sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks;
  logic rsp_valid, rsp_error;

  logic rand_en = 1'b0;
  logic [NB-1:0] dir_kill = '0, dir_incept = '0, dir_send = '0, dir_stream = '0;
  logic [NB-1:0] rnd_kill = '0, rnd_incept = '0, rnd_send = '0, rnd_stream = '0;

  assign sender_kill_acks   = rand_en ? rnd_kill   : dir_kill;
  assign sender_incept_acks = rand_en ? rnd_incept : dir_incept;
  assign sender_send_acks   = rand_en ? rnd_send   : dir_send;
  assign sender_stream_acks = rand_en ? rnd_stream : dir_stream;

  always #5 clk = ~clk;

  uarc_send_sched #(.WORD_MAG(WORD_MAG), .UARC_SETS(UARC_SETS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bus(cmd_bus), .cmd_last(cmd_last), .cmd_data(cmd_data),
    .cmd_self_permission(cmd_self_permission), .cmd_self_address(cmd_self_address),
    .cmd_incept_permission(cmd_incept_permission), .cmd_incept_address(cmd_incept_address),
    .global_kill(global_kill), .global_incept(global_incept), .global_send(global_send),
    .global_stream(global_stream), .global_data(global_data),
    .global_self_permission(global_self_permission), .global_self_address(global_self_address),
    .global_incept_permission(global_incept_permission), .global_incept_address(global_incept_address),
    .sender_enables(sender_enables), .sender_kill_acks(sender_kill_acks),
    .sender_incept_acks(sender_incept_acks), .sender_send_acks(sender_send_acks),
    .sender_stream_acks(sender_stream_acks), .rsp_valid(rsp_valid), .rsp_error(rsp_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: one transfer in flight, an optional stream lock, a pending response.
  bit m_busy = 0, m_lock = 0, m_rsp = 0, m_err = 0, m_last = 0;
  int m_bus = 0, m_age = 0;
  logic [1:0] m_op = '0;
  logic [WW-1:0] m_pay [5] = '{default: '0};
  logic [NB-1:0] av;
  logic [NB-1:0] exp_en;

  function automatic logic exp_ready();
    return reset && !m_busy && !m_rsp && (!m_lock || cmd_op == 2'd3);
  endfunction

  function automatic logic [NB-1:0] ack_of(input logic [1:0] op);
    case (op)
      2'd0: return sender_kill_acks;
      2'd1: return sender_incept_acks;
      2'd2: return sender_send_acks;
      default: return sender_stream_acks;
    endcase
  endfunction

  task automatic age_out();
    m_age++;
    if (TO_EN && m_age == TIMEOUT) begin
      m_busy = 0; m_lock = 0; m_rsp = 1; m_err = 1; m_age = 0;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_lock = 0; m_rsp = 0; m_err = 0; m_last = 0; m_bus = 0; m_op = '0; m_age = 0;
      for (int i = 0; i < 5; i++) m_pay[i] = '0;
    end else if (m_rsp) begin
      m_rsp = 0;
    end else if (m_busy) begin
      av = ack_of(m_op);
      if (av[m_bus]) begin
        m_busy = 0; m_age = 0;
        if (m_op == 2'd3 && !m_last) m_lock = 1;
        else begin m_lock = 0; m_rsp = 1; m_err = 0; end
      end else age_out();
    end else if (cmd_valid && exp_ready()) begin
      m_age = 0;
      if (m_lock || cmd_bus < NB) begin
        m_busy = 1; m_last = cmd_last;
        m_op = m_lock ? 2'd3 : cmd_op;
        if (!m_lock) m_bus = cmd_bus;
        m_pay[0] = cmd_data; m_pay[1] = cmd_self_permission; m_pay[2] = cmd_self_address;
        m_pay[3] = cmd_incept_permission; m_pay[4] = cmd_incept_address;
      end else begin
        m_rsp = 1; m_err = 1;
      end
    end else if (m_lock) age_out();
  end

  always @(negedge clk) begin
    exp_en = (m_busy || m_lock) ? (NB'(1) << m_bus) : '0;
    chk("cmd_ready", cmd_ready, exp_ready());
    chk("enables", sender_enables, exp_en);
    chk("kill", global_kill, m_busy && m_op == 2'd0);
    chk("incept", global_incept, m_busy && m_op == 2'd1);
    chk("send", global_send, m_busy && m_op == 2'd2);
    chk("stream", global_stream, m_busy && m_op == 2'd3);
    chk("rsp_valid", rsp_valid, m_rsp);
    chk("rsp_error", rsp_error, m_rsp && m_err);
    chk("data", global_data, m_pay[0]);
    chk("self_perm", global_self_permission, m_pay[1]);
    chk("self_addr", global_self_address, m_pay[2]);
    chk("inc_perm", global_incept_permission, m_pay[3]);
    chk("inc_addr", global_incept_address, m_pay[4]);
  end

  // Random ack responder: sometimes acks the enabled bus on an op vector, plus stray bits.
  initial forever begin
    @(posedge clk); #1;
    rnd_kill   = ($urandom_range(0, 3) == 0 ? sender_enables : '0) | (NB'($urandom_range(0, 1)) << $urandom_range(0, NB - 1));
    rnd_incept = ($urandom_range(0, 3) == 0 ? sender_enables : '0) | (NB'($urandom_range(0, 1)) << $urandom_range(0, NB - 1));
    rnd_send   = ($urandom_range(0, 3) == 0 ? sender_enables : '0) | (NB'($urandom_range(0, 1)) << $urandom_range(0, NB - 1));
    rnd_stream = ($urandom_range(0, 3) == 0 ? sender_enables : '0) | (NB'($urandom_range(0, 1)) << $urandom_range(0, NB - 1));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input int bus, input logic last, input logic [WW-1:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_bus = BW'(bus); cmd_last = last; cmd_data = d;
    cmd_self_permission = $urandom; cmd_self_address = $urandom;
    cmd_incept_permission = $urandom; cmd_incept_address = $urandom;
  endtask

  task automatic accept_wait();
    int waited;
    logic acc;
    waited = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk); acc = cmd_ready;
      tick();
      waited++;
      // A non-stream command stalls behind a held stream; turn it into a continuation word.
      if (waited == 4) cmd_op = 2'd3;
      if (!acc && waited > 500) begin
        checks++; errors++;
        $display("FAIL accept_wait t=%0t got no accept want accept within 500 cycles", $time);
        acc = 1'b1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  bit en_ok, stall_ok, k_ok;
  int rcnt, sends, rv;

  task automatic obs7();
    @(negedge clk);
    if (sender_enables !== (NB'(1) << 7)) en_ok = 0;
    if (rsp_valid) rcnt++;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_enables", sender_enables, '0);
    chk("rst_rsp", rsp_valid, 1'b0);
    chk("rst_data", global_data, '0);
    tick(); reset = 1'b1; tick();

    // SEND on bus 3, acked in the fourth drive cycle.
    set_cmd(2'd2, 3, 1'b0, 32'hDEADBEEF); tick(); cmd_valid = 1'b0;
    sends = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) dir_send = NB'(1) << 3;
      @(negedge clk);
      if (global_send && sender_enables === (NB'(1) << 3)) sends++;
      tick();
    end
    dir_send = '0;
    @(negedge clk);
    chk("send_cycles", sends, 4);
    chk("send_rsp", rsp_valid, 1'b1);
    chk("send_err", rsp_error, 1'b0);
    chk("send_drop", {sender_enables, global_send}, '0);
    chk("send_data", global_data, 32'hDEADBEEF);
    tick(); @(negedge clk);
    chk("send_rsp_once", rsp_valid, 1'b0);
    tick();

    // KILL on bus 2: wrong-bus and wrong-op acks ignored.
    set_cmd(2'd0, 2, 1'b0, 32'h0000CAFE); tick(); cmd_valid = 1'b0;
    dir_kill = NB'(1) << 5; dir_send = NB'(1) << 2; k_ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (!(global_kill && sender_enables === (NB'(1) << 2) && !rsp_valid)) k_ok = 0;
      tick();
    end
    chk("kill_ignore", k_ok, 1'b1);
    dir_kill = NB'(1) << 2; dir_send = '0; tick(); dir_kill = '0;
    @(negedge clk);
    chk("kill_rsp", rsp_valid, 1'b1);
    chk("kill_err", rsp_error, 1'b0);
    tick();

    // STREAM on bus 7, three words, SEND offered mid-burst.
    set_cmd(2'd3, 7, 1'b0, 32'h1); tick(); cmd_valid = 1'b0;
    en_ok = 1; rcnt = 0; stall_ok = 1;
    dir_stream = NB'(1) << 7; obs7(); tick(); dir_stream = '0;
    set_cmd(2'd2, 9, 1'b0, 32'hBAD); obs7(); if (cmd_ready) stall_ok = 0; tick();
    obs7(); if (cmd_ready) stall_ok = 0; tick();
    set_cmd(2'd3, 20, 1'b0, 32'h2); obs7(); tick(); cmd_valid = 1'b0;
    dir_stream = NB'(1) << 7; obs7(); chk("stream_w2_data", global_data, 32'h2); tick(); dir_stream = '0;
    set_cmd(2'd3, 7, 1'b1, 32'h3); obs7(); tick(); cmd_valid = 1'b0;
    dir_stream = NB'(1) << 7; obs7(); tick(); dir_stream = '0;
    @(negedge clk);
    chk("stream_en_held", en_ok, 1'b1);
    chk("stream_stall", stall_ok, 1'b1);
    chk("stream_mid_rsp", rcnt, 0);
    chk("stream_rsp", rsp_valid, 1'b1);
    chk("stream_data", global_data, 32'h3);
    tick();

    // Out-of-range bus.
    set_cmd(2'd1, NB, 1'b0, 32'h55); tick(); cmd_valid = 1'b0;
    @(negedge clk);
    chk("oor_rsp", rsp_valid, 1'b1);
    chk("oor_err", rsp_error, 1'b1);
    chk("oor_en", sender_enables, '0);
    tick();

`ifdef UARC_SEND_TIMEOUT_EN
    set_cmd(2'd2, 4, 1'b0, 32'h77); tick(); cmd_valid = 1'b0;
    sends = 0;
    for (int k = 0; k < 20 && !rsp_valid; k++) begin
      @(negedge clk); if (global_send) sends++;
      if (!rsp_valid) tick();
    end
    chk("to_cycles", sends, TIMEOUT);
    chk("to_err", rsp_error, 1'b1);
    chk("to_en", sender_enables, '0);
    tick();
`endif

    // Reset in the middle of a drive.
    set_cmd(2'd2, 5, 1'b0, 32'h12345678); tick(); cmd_valid = 1'b0; tick();
    reset = 1'b0; #1;
    chk("rstmid_en", sender_enables, '0);
    chk("rstmid_send", global_send, 1'b0);
    chk("rstmid_data", global_data, '0);
    chk("rstmid_ready", cmd_ready, 1'b0);
    tick(); reset = 1'b1;
    rv = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) rv++; tick(); end
    chk("rstmid_no_rsp", rv, 0);

    rand_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      set_cmd(2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? $urandom_range(NB, 127) : $urandom_range(0, NB - 1),
              1'($urandom_range(0, 2) == 0), $urandom);
      accept_wait();
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_en = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1);
  end

endmodule
